// File: rtl/dino_pkg.sv
// Shared types and default timing constants for the dino game datapath.
package dino_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    JUMP = 1'b1
  } jump_state_t;

  localparam int JUMP_LEN_DEF = 51;
  localparam int TICK_DIV_DEF = 251250;

endpackage

// File: rtl/jump_sequencer_if.sv
// Button/halt request side and trajectory outputs of the jump sequencer.
interface jump_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              button;
  logic              halt;
  logic [ADDR_W-1:0] movaddr;
  logic              busy;
  logic              apex;
  logic              done;

  modport master (
    output button, halt,
    input  movaddr, busy, apex, done
  );

  modport slave (
    input  button, halt,
    output movaddr, busy, apex, done
  );
endinterface

// File: rtl/jump_sequencer_tick_divider.sv
// Free-running clock divider: tick on the last count of every DIV enabled cycles.
module tick_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en & (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/jump_sequencer.sv
// Jump trajectory sequencer: walks the jump-height ROM address on a button press.
module jump_sequencer
  import dino_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int JUMP_LEN = JUMP_LEN_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter bit QUEUE_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  jump_sequencer_if.slave js
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(JUMP_LEN - 1);
  localparam logic [ADDR_W-1:0] APEX_ADDR = ADDR_W'(JUMP_LEN / 2);

  jump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] movaddr_q, movaddr_d;
  logic              queued_q, queued_d;
  logic              button_q;
  logic              busy_q, apex_q, apex_d, done_q, done_d;
  logic              press_ok;
  logic              tick;
  logic [ADDR_W-1:0] addr_inc;

  // Halt gates the divider enable, so tick is already zero while frozen.
  tick_divider #(.DIV(TICK_DIV)) u_div (
    .clk  (clk),
    .reset(reset),
    .en   ((state_q == JUMP) & ~js.halt),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  assign press_ok = js.button & ~button_q & ~js.halt;
  assign addr_inc = movaddr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    movaddr_d = movaddr_q;
    queued_d  = queued_q;
    apex_d    = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        movaddr_d = '0;
        queued_d  = 1'b0;
        if (press_ok) state_d = JUMP;
      end
      JUMP: begin
        if (QUEUE_EN && press_ok) queued_d = 1'b1;
        if (tick) begin
          if (movaddr_q != LAST_ADDR) begin
            movaddr_d = addr_inc;
            apex_d    = (addr_inc == APEX_ADDR);
          end else begin
            // A press on the landing tick itself counts as the queued re-jump.
            movaddr_d = '0;
            done_d    = 1'b1;
            queued_d  = 1'b0;
            if (!(queued_q || (QUEUE_EN && press_ok))) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      movaddr_q <= '0;
      queued_q  <= 1'b0;
      button_q  <= 1'b0;
      busy_q    <= 1'b0;
      apex_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      movaddr_q <= movaddr_d;
      queued_q  <= queued_d;
      button_q  <= js.button;
      busy_q    <= (state_d == JUMP);
      apex_q    <= apex_d;
      done_q    <= done_d;
    end
  end

  assign js.movaddr = movaddr_q;
  assign js.busy    = busy_q;
  assign js.apex    = apex_q;
  assign js.done    = done_q;
endmodule
